// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the dual-issue fetch buffer.
package fetch_pkg;
    localparam int INST_W = 16;
    localparam int PAIR_PC_W = 16;
    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;
    typedef struct packed {
        logic [INST_W-1:0]    inst1;
        logic [INST_W-1:0]    inst0;
        logic [PAIR_PC_W-1:0] pc;
    } inst_pair_t;
endpackage

// File: rtl/fetchbuf_fifo.sv
// fetchbuf_fifo: circular queue of instruction pairs with flush and occupancy count.
module fetchbuf_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  inst_pair_t  wdata,
    output inst_pair_t  rdata,
    output logic [AW:0] count
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    inst_pair_t    mem_q [DEPTH];
    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end
    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: sequential pair fetch, credit-limited queue, redirect flush.
// Define FETCHBUF_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              fetch_next,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst0,
    output logic [INST_W-1:0] dec_inst1,
    output logic [PC_W-1:0]   dec_pc,
    output logic              empty,
    output logic              full
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [PC_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   count;
    inst_pair_t      head, resp, pair;
    logic            rsp_ok, byp, pop_any, pop, push;
    fetchbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (resp),
        .rdata (head),
        .count (count)
    );
    // Only a response to a request we issued since reset counts; stale ones after reset are ignored.
    always_comb begin
        rsp_ok = imem_rvalid && inflight_q && !redirect;
        resp   = '{inst1: imem_rdata[31:16], inst0: imem_rdata[15:0], pc: PAIR_PC_W'(req_pc_q)};
`ifdef FETCHBUF_BYPASS_EN
        byp    = rsp_ok && (count == '0);
`else
        byp    = 1'b0;
`endif
        dec_valid  = (count != '0) || byp;
        pop_any    = fetch_next && dec_valid && !redirect;
        pop        = pop_any && !byp;
        push       = rsp_ok && !(byp && fetch_next);
        imem_req   = rst_n && !redirect &&
                     (({1'b0, count} + (CW+1)'(inflight_q)) < ((CW+1)'(DEPTH) + (CW+1)'(pop_any)));
        pair       = byp ? resp : head;
        dec_inst0  = dec_valid ? pair.inst0 : NOP_INST;
        dec_inst1  = dec_valid ? pair.inst1 : NOP_INST;
        dec_pc     = dec_valid ? PC_W'(pair.pc) : '0;
        pc_d       = redirect ? (redirect_pc & ~PC_W'(1)) : imem_req ? pc_q + PC_W'(2) : pc_q;
        req_pc_d   = imem_req ? pc_q : req_pc_q;
        inflight_d = imem_req;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end
    assign imem_addr = pc_q;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed table, corner sequences and random traffic against a queue-based model.
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_next;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        dec_valid;
    logic [15:0] dec_inst0, dec_inst1, dec_pc;
    logic        empty, full;

    int checks = 0;
    int failures = 0;

    logic [15:0] mq[$];
    logic [15:0] m_pc, m_inf_pc;
    bit          m_inf;

    typedef struct {
        bit          fn;
        bit          req;
        logic [15:0] addr;
        bit          v;
        logic [15:0] pc;
        bit          full;
    } vec_t;
    vec_t tbl[11];
    bit hz[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    fetch_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .fetch_next  (fetch_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_inst0   (dec_inst0),
        .dec_inst1   (dec_inst1),
        .dec_pc      (dec_pc),
        .empty       (empty),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Memory answers every request one cycle later with address-tagged data.
    always @(posedge clk) begin
        imem_rvalid <= imem_req;
        imem_rdata  <= {imem_addr + 16'd1, imem_addr ^ 16'hA5A5};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_step(input bit rd, input bit fn, input logic [15:0] rp);
        bit          v;
        bit          pop;
        bit          req;
        logic [15:0] hp;
        v   = mq.size() > 0;
        hp  = v ? mq[0] : 16'h0;
        pop = fn && v && !rd;
        req = !rd && ((mq.size() + int'(m_inf) - int'(pop)) < 4);
        chk("req", imem_req, req);
        chk("addr", imem_addr, m_pc);
        chk("valid", dec_valid, v);
        chk("pc", dec_pc, hp);
        chk("inst0", dec_inst0, v ? (hp ^ 16'hA5A5) : 16'h0);
        chk("inst1", dec_inst1, v ? (hp + 16'd1) : 16'h0);
        chk("full", full, mq.size() == 4);
        chk("empty", empty, mq.size() == 0);
        if (rd) begin
            mq.delete();
            m_pc  = rp & 16'hFFFE;
            m_inf = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_inf) mq.push_back(m_inf_pc);
            if (req) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 16'd2;
            end
            m_inf = req;
        end
    endtask

    task automatic cycle(input bit rd, input bit fn, input logic [15:0] rp);
        redirect    = rd;
        fetch_next  = fn;
        redirect_pc = rp;
        @(negedge clk);
        model_step(rd, fn, rp);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = 16'h0;
        m_inf = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, 16'h0);
        chk({tag, "_valid"}, dec_valid, 1'b0);
        chk({tag, "_inst0"}, dec_inst0, 16'h0);
        chk({tag, "_inst1"}, dec_inst1, 16'h0);
        chk({tag, "_pc"}, dec_pc, 16'h0);
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_full"}, full, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 16'd0,  0, 16'd0, 0};
        tbl[1]  = '{1, 1, 16'd2,  0, 16'd0, 0};
        tbl[2]  = '{1, 1, 16'd4,  1, 16'd0, 0};
        tbl[3]  = '{1, 1, 16'd6,  1, 16'd2, 0};
        tbl[4]  = '{1, 1, 16'd8,  1, 16'd4, 0};
        tbl[5]  = '{0, 1, 16'd10, 1, 16'd6, 0};
        tbl[6]  = '{0, 1, 16'd12, 1, 16'd6, 0};
        tbl[7]  = '{0, 0, 16'd14, 1, 16'd6, 0};
        tbl[8]  = '{0, 0, 16'd14, 1, 16'd6, 1};
        tbl[9]  = '{1, 1, 16'd14, 1, 16'd6, 1};
        tbl[10] = '{1, 1, 16'd16, 1, 16'd8, 0};

        rst_n = 1'b0;
        redirect = 1'b0;
        fetch_next = 1'b0;
        redirect_pc = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 11; i++) begin
            fetch_next = tbl[i].fn;
            #2;
            chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), dec_valid, tbl[i].v);
            chk($sformatf("tbl%0d_pc", i), dec_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].full);
            cycle(1'b0, tbl[i].fn, 16'h0);
        end

        repeat (10) cycle(1'b0, 1'b1, 16'h0);

        // Redirect while a response is arriving: it must be discarded.
        cycle(1'b1, 1'b1, 16'h0041);
        redirect = 1'b0;
        fetch_next = 1'b1;
        #1;
        chk("rd41_valid", dec_valid, 1'b0);
        chk("rd41_req", imem_req, 1'b1);
        chk("rd41_addr", imem_addr, 16'h0040);
        cycle(1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b1, 16'h0);
        chk("rd41_valid3", dec_valid, 1'b1);
        chk("rd41_pc3", dec_pc, 16'h0040);

        // Redirect together with fetch_next at a full queue.
        repeat (8) cycle(1'b0, 1'b0, 16'h0);
        chk("fill_full", full, 1'b1);
        chk("fill_noreq", imem_req, 1'b0);
        cycle(1'b1, 1'b1, 16'h0100);
        redirect = 1'b0;
        fetch_next = 1'b0;
        #1;
        chk("rdfull_empty", empty, 1'b1);
        chk("rdfull_valid", dec_valid, 1'b0);
        chk("rdfull_req", imem_req, 1'b1);
        chk("rdfull_addr", imem_addr, 16'h0100);

        for (int i = 0; i < 20; i++) cycle(1'b0, hz[i % 6], 16'h0);

        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, 16'($urandom));

        // Asynchronous reset with a full queue.
        repeat (8) cycle(1'b0, 1'b0, 16'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b1, 16'h0);
        chk("restart_valid", dec_valid, 1'b1);
        chk("restart_pc", dec_pc, 16'h0);
        repeat (20) cycle(1'b0, 1'b1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
